// File: rtl/dl166_run_ctrl.sv
// Run controller for the DL166 core: holds the core in reset after power-up and gates its
// per-instruction enable for RUN / HALT / single-STEP, with rate select, PC breakpoint and counter.
module dl166_run_ctrl #(
    parameter int RST_CYC      = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int AUTO_RUN     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_btn,
    input  logic       step_btn,
    input  logic       halt_btn,
    input  logic       soft_rst,
    input  logic [3:0] div_sel,
    input  logic       bp_en,
    input  logic [3:0] bp_addr,
    input  logic [3:0] pc,
    output logic       cpu_en,
    output logic       cpu_rst_n,
    output logic [1:0] state,
    output logic [7:0] instr_cnt,
    output logic       bp_hit
);

    typedef enum logic [1:0] {
        S_RESET_HOLD = 2'd0,
        S_HALT       = 2'd1,
        S_RUN        = 2'd2,
        S_STEP       = 2'd3
    } state_e;

    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [15:0]     RST_LAST = 16'(RST_CYC - 1);

    // Button vectors are ordered {halt, step, run}.
    logic [2:0]      btn_raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      db_q, db_d, db_prev_q;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];
    logic [2:0]      press;
    logic            run_ev, step_ev, halt_ev;

    state_e          state_q, state_d;
    logic [15:0]     pre_q, pre_d;
    logic [15:0]     mask;
    logic            tick;
    logic            first_q, first_d;
    logic [7:0]      instr_q, instr_d;
    logic            bp_hit_q, bp_hit_d;
    logic            cpu_en_c;
    logic            bp_set;

    assign btn_raw = {halt_btn, step_btn, run_btn};

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press   = db_q & ~db_prev_q;
    assign run_ev  = press[0];
    assign step_ev = press[1];
    assign halt_ev = press[2];

    assign mask = (16'd1 << div_sel) - 16'd1;
    assign tick = ((pre_q & mask) == mask);

    always_comb begin
        state_d  = state_q;
        cpu_en_c = 1'b0;
        bp_set   = 1'b0;
        if (soft_rst) begin
            state_d = S_RESET_HOLD;
        end else begin
            case (state_q)
                S_RESET_HOLD: begin
                    if (pre_q == RST_LAST) begin
                        state_d = (AUTO_RUN != 0) ? S_RUN : S_HALT;
                    end
                end
                S_HALT: begin
                    // A coinciding halt press outranks step/run, and halt itself is a no-op here.
                    if (!halt_ev) begin
                        if (step_ev) begin
                            state_d = S_STEP;
                        end else if (run_ev) begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (halt_ev) begin
                        state_d = S_HALT;
                    end else if (tick) begin
                        if (bp_en && (pc == bp_addr) && !first_q) begin
                            state_d = S_HALT;
                            bp_set  = 1'b1;
                        end else begin
                            cpu_en_c = 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    if (halt_ev) begin
                        state_d = S_HALT;
                    end else if (tick) begin
                        cpu_en_c = 1'b1;
                        state_d  = S_HALT;
                    end
                end
                default: state_d = S_RESET_HOLD;
            endcase
        end
    end

    // The prescaler doubles as the cycle-in-state counter; soft_rst restarts it even in RESET_HOLD.
    always_comb begin
        pre_d = pre_q + 16'd1;
        if ((state_d != state_q) || soft_rst) begin
            pre_d = '0;
        end

        first_d = first_q;
        if ((state_d == S_RUN) && (state_q != S_RUN)) begin
            first_d = 1'b1;
        end else if ((state_q == S_RUN) && tick) begin
            first_d = 1'b0;
        end

        instr_d = instr_q + {7'd0, cpu_en_c};
        if (state_d == S_RESET_HOLD) begin
            instr_d = '0;
        end

        bp_hit_d = bp_hit_q;
        if (state_d == S_RESET_HOLD) begin
            bp_hit_d = 1'b0;
        end else if ((state_d != state_q) && ((state_d == S_RUN) || (state_d == S_STEP))) begin
            bp_hit_d = 1'b0;
        end else if (bp_set) begin
            bp_hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
            state_q   <= S_RESET_HOLD;
            pre_q     <= '0;
            first_q   <= 1'b0;
            instr_q   <= '0;
            bp_hit_q  <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q   <= state_d;
            pre_q     <= pre_d;
            first_q   <= first_d;
            instr_q   <= instr_d;
            bp_hit_q  <= bp_hit_d;
        end
    end

    assign cpu_en    = cpu_en_c;
    assign cpu_rst_n = (state_q != S_RESET_HOLD);
    assign state     = state_q;
    assign instr_cnt = instr_q;
    assign bp_hit    = bp_hit_q;

endmodule

// File: tb/tb_dl166_run_ctrl.sv
// Directed bench for dl166_run_ctrl: inputs change just after the falling edge, outputs are
// checked at the falling edge; a small core model advances pc on each enable.
module tb_dl166_run_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       run_btn, step_btn, halt_btn, soft_rst;
    logic [3:0] div_sel, bp_addr;
    logic       bp_en;
    logic [3:0] pc = 4'd0;
    logic       cpu_en, cpu_rst_n, bp_hit;
    logic [1:0] state;
    logic [7:0] instr_cnt;

    int tests = 0;
    int fails = 0;

    dl166_run_ctrl #(
        .RST_CYC      (4),
        .DEBOUNCE_CYC (16),
        .AUTO_RUN     (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run_btn   (run_btn),
        .step_btn  (step_btn),
        .halt_btn  (halt_btn),
        .soft_rst  (soft_rst),
        .div_sel   (div_sel),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .cpu_en    (cpu_en),
        .cpu_rst_n (cpu_rst_n),
        .state     (state),
        .instr_cnt (instr_cnt),
        .bp_hit    (bp_hit)
    );

    always #5 clk = ~clk;

    // Core model: PC clears under core reset and advances once per executed instruction.
    always @(posedge clk) begin
        if (!cpu_rst_n) pc <= 4'd0;
        else if (cpu_en) pc <= pc + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int k;
        k = 0;
        while ((state !== s) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {30'd0, state}, {30'd0, s});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run_btn = 1'b0; step_btn = 1'b0; halt_btn = 1'b0; soft_rst = 1'b0;
        div_sel = 4'd0; bp_en = 1'b0; bp_addr = 4'd0;
        cyc(3);
        chk("rst_state", state, 0);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_instr_cnt", instr_cnt, 0);
        chk("rst_bp_hit", bp_hit, 0);

        // Reset hold: four cycles with the core held in reset, then HALT.
        reset = 1'b0;
        for (int i = 1; i < 4; i++) begin
            cyc(1);
            chk("hold_cpu_rst_n", cpu_rst_n, 0);
            chk("hold_state", state, 0);
        end
        cyc(1);
        chk("hold_exit_state", state, 1);
        chk("hold_exit_rst_n", cpu_rst_n, 1);
        chk("hold_exit_en", cpu_en, 0);
        chk("hold_exit_cnt", instr_cnt, 0);

        // Short glitch on run must not be accepted.
        div_sel = 4'd2;
        run_btn = 1'b1; cyc(10); run_btn = 1'b0; cyc(30);
        chk("glitch_state", state, 1);

        // Real press: RUN begins 19 cycles after the level is applied.
        run_btn = 1'b1;
        cyc(18);
        chk("press_before", state, 1);
        cyc(1);
        chk("press_at", state, 2);
        for (int i = 0; i < 40; i++) begin
            chk("rate_div2", cpu_en, (i % 4) == 3);
            if (i == 11) run_btn = 1'b0;
            cyc(1);
        end
        chk("cnt_after_40", instr_cnt, 10);

        // Full speed until the counter wraps.
        div_sel = 4'd0;
        cyc(245);
        chk("cnt_255", instr_cnt, 255);
        cyc(1);
        chk("cnt_wrap", instr_cnt, 0);

        // Halt and step pressed together in RUN: halt wins, no pulse in the event cycle.
        halt_btn = 1'b1; step_btn = 1'b1;
        cyc(18);
        chk("prio_event_en", cpu_en, 0);
        chk("prio_event_state", state, 2);
        cyc(1);
        chk("prio_state", state, 1);
        chk("prio_cnt", instr_cnt, 18);
        halt_btn = 1'b0; step_btn = 1'b0;
        cyc(25);

        // Single step at div_sel=1: pulse in the second STEP cycle, then HALT.
        div_sel = 4'd1;
        step_btn = 1'b1;
        cyc(18);
        chk("step_before", state, 1);
        cyc(1);
        chk("step_state", state, 3);
        chk("step_en0", cpu_en, 0);
        cyc(1);
        chk("step_en1", cpu_en, 1);
        cyc(1);
        chk("step_back_halt", state, 1);
        chk("step_after_en", cpu_en, 0);
        chk("step_cnt", instr_cnt, 19);
        step_btn = 1'b0;
        cyc(25);

        // Soft reset in the middle of full-speed RUN.
        div_sel = 4'd0;
        run_btn = 1'b1;
        cyc(19);
        chk("srst_run", state, 2);
        cyc(3);
        chk("srst_cnt_before", instr_cnt, 22);
        run_btn = 1'b0;
        soft_rst = 1'b1;
        #1;
        chk("srst_en_suppressed", cpu_en, 0);
        cyc(1);
        soft_rst = 1'b0;
        chk("srst_state", state, 0);
        chk("srst_cnt", instr_cnt, 0);
        chk("srst_rst_n", cpu_rst_n, 0);
        for (int i = 1; i < 4; i++) begin
            cyc(1);
            chk("srst_hold_rst_n", cpu_rst_n, 0);
        end
        cyc(1);
        chk("srst_exit_state", state, 1);
        chk("srst_exit_rst_n", cpu_rst_n, 1);
        cyc(25);

        // Breakpoint at PC 5 from a fresh core.
        bp_en = 1'b1; bp_addr = 4'd5;
        run_btn = 1'b1;
        cyc(19);
        chk("bp_run", state, 2);
        chk("bp_first_en", cpu_en, 1);
        cyc(1);
        run_btn = 1'b0;
        cyc(4);
        chk("bp_stop_en", cpu_en, 0);
        chk("bp_stop_state", state, 2);
        cyc(1);
        chk("bp_halt", state, 1);
        chk("bp_hit_set", bp_hit, 1);
        chk("bp_cnt", instr_cnt, 5);
        chk("bp_pc", pc, 5);
        cyc(25);

        // Resume off the breakpoint: executes PC 5, wraps, stops at 5 again.
        run_btn = 1'b1;
        cyc(19);
        chk("bp2_run", state, 2);
        chk("bp2_hit_clr", bp_hit, 0);
        chk("bp2_first_en", cpu_en, 1);
        cyc(1);
        run_btn = 1'b0;
        wait_state(2'd1, 40, "bp2_halt");
        chk("bp2_cnt", instr_cnt, 21);
        chk("bp2_hit", bp_hit, 1);
        chk("bp2_pc", pc, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
